// File: rtl/fp32_pkg.sv
// ----------------------------------------------------------------------------
// fp32_pkg
// Shared definitions for the binary32 power datapath:
//   - field widths and exponent bias
//   - canonical constants (1.0, quiet NaN, +inf)
//   - operand classification type and helper
//   - FSM state encoding for nth_power_fp
// ----------------------------------------------------------------------------
package fp32_pkg;

    localparam int FP32_EXP_W   = 8;
    localparam int FP32_FRAC_W  = 23;
    localparam int FP32_MANT_W  = 24;   // hidden one + fraction
    localparam int FP32_XEXP_W  = 16;   // internal signed exponent width
    localparam int FP32_BIAS    = 127;

    localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP32_INF  = 32'h7F80_0000;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,    // zero or denormal (denormals flushed)
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_t;

    // FSM state encoding
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_ACC  = 2'd1;
    localparam fsm_state_t ST_SQR  = 2'd2;
    localparam fsm_state_t ST_PACK = 2'd3;

    function automatic fp_class_t fp32_classify(input logic [31:0] v);
        fp_class_t cls;
        if (v[30:23] == 8'hFF) begin
            cls = (v[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
        end else if (v[30:23] == 8'h00) begin
            cls = CLS_ZERO;
        end else begin
            cls = CLS_NORM;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp_mant_mul.sv
// ----------------------------------------------------------------------------
// fp_mant_mul
// Combinational normalized mantissa multiplier.
// Multiplies two 1.23 mantissas (hidden one explicit) and adds their signed
// exponents. The product lies in [1,4); when it reaches 2 the mantissa is
// shifted right by one and the exponent incremented. Lower bits are
// truncated (no rounding).
// Ports:
//   a_mant, b_mant  in  24b  mantissas 1.F
//   a_exp,  b_exp   in  16b  signed unbiased exponents
//   p_mant          out 24b  normalized truncated product mantissa
//   p_exp           out 16b  signed product exponent
// ----------------------------------------------------------------------------
module fp_mant_mul
    import fp32_pkg::*;
(
    input  logic        [FP32_MANT_W-1:0] a_mant,
    input  logic signed [FP32_XEXP_W-1:0] a_exp,
    input  logic        [FP32_MANT_W-1:0] b_mant,
    input  logic signed [FP32_XEXP_W-1:0] b_exp,
    output logic        [FP32_MANT_W-1:0] p_mant,
    output logic signed [FP32_XEXP_W-1:0] p_exp
);

    // Only product bits [47:23] ever reach the output, so keep just those.
    logic [FP32_MANT_W:0] prod_top;
    logic signed [FP32_XEXP_W-1:0] exp_sum;

    assign prod_top = 25'((48'(a_mant) * 48'(b_mant)) >> 23);
    assign exp_sum  = a_exp + b_exp;

    always_comb begin
        if (prod_top[FP32_MANT_W]) begin
            p_mant = prod_top[FP32_MANT_W:1];
            p_exp  = exp_sum + 16'sd1;
        end else begin
            p_mant = prod_top[FP32_MANT_W-1:0];
            p_exp  = exp_sum;
        end
    end

endmodule

// File: rtl/nth_power_fp.sv
// ----------------------------------------------------------------------------
// nth_power_fp
// Iterative binary32 integer power: result = value^N, N unsigned 8 bits.
// Square-and-multiply, LSB first, over one shared fp_mant_mul instance.
// Each of the 8 exponent bits takes one ACC cycle (conditional multiply into
// the accumulator) and one SQR cycle (base squared), followed by one PACK
// cycle, giving a fixed 18-cycle latency from acceptance to done for every
// operand and every N.
//
// Optional feature macro: NTH_POWER_FLAGS_EN
//   defined   -> overflow/underflow ports and registers exist, valid with done
//   undefined -> those ports are absent; saturation to inf/zero still occurs
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request, sampled only when idle and not during done
//   value      in   32b binary32 operand
//   N          in   8b unsigned exponent
//   busy       out  operation in flight
//   done       out  one-cycle pulse, result valid
//   result     out  32b binary32 value^N, held until next done
//   overflow   out  (NTH_POWER_FLAGS_EN) result saturated to inf
//   underflow  out  (NTH_POWER_FLAGS_EN) result flushed to zero
// ----------------------------------------------------------------------------
module nth_power_fp
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] value,
    input  logic [7:0]  N,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
`ifdef NTH_POWER_FLAGS_EN
    ,
    output logic        overflow,
    output logic        underflow
`endif
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fsm_state_t                     state_reg;
    logic [2:0]                     bit_idx_reg;
    logic [7:0]                     n_reg;
    logic                           sign_reg;
    fp_class_t                      cls_reg;
    logic        [FP32_MANT_W-1:0]  base_mant_reg;
    logic signed [FP32_XEXP_W-1:0]  base_exp_reg;
    logic        [FP32_MANT_W-1:0]  acc_mant_reg;
    logic signed [FP32_XEXP_W-1:0]  acc_exp_reg;
    logic                           busy_reg;
    logic                           done_reg;
    logic [31:0]                    result_reg;

    // ------------------------------------------------------------------
    // Shared multiplier: ACC multiplies acc*base, every other state base*base
    // ------------------------------------------------------------------
    logic        [FP32_MANT_W-1:0]  mul_a_mant;
    logic signed [FP32_XEXP_W-1:0]  mul_a_exp;
    logic        [FP32_MANT_W-1:0]  mul_p_mant;
    logic signed [FP32_XEXP_W-1:0]  mul_p_exp;

    assign mul_a_mant = (state_reg == ST_ACC) ? acc_mant_reg : base_mant_reg;
    assign mul_a_exp  = (state_reg == ST_ACC) ? acc_exp_reg  : base_exp_reg;

    fp_mant_mul u_mul (
        .a_mant (mul_a_mant),
        .a_exp  (mul_a_exp),
        .b_mant (base_mant_reg),
        .b_exp  (base_exp_reg),
        .p_mant (mul_p_mant),
        .p_exp  (mul_p_exp)
    );

    // ------------------------------------------------------------------
    // Load-time operand decode
    // ------------------------------------------------------------------
    logic signed [FP32_XEXP_W-1:0]  load_exp;
    assign load_exp = $signed({8'h00, value[30:23]}) - 16'sd127;

    // ------------------------------------------------------------------
    // Result packing (evaluated in PACK)
    // ------------------------------------------------------------------
    logic signed [FP32_XEXP_W:0]    biased_exp;
    logic                           res_sign;
    logic                           is_finite_pow;
    logic                           sat_ovf;
    logic                           sat_udf;
    logic [31:0]                    pack_result_next;

    // One extra bit so the +bias can never wrap near the exponent limits.
    assign biased_exp    = $signed({acc_exp_reg[FP32_XEXP_W-1], acc_exp_reg}) + 17'sd127;
    assign res_sign      = sign_reg & n_reg[0];
    // Range saturation only applies to a normal operand raised to N>0;
    // the special classes are resolved ahead of it in the priority chain.
    assign is_finite_pow = (cls_reg == CLS_NORM) && (n_reg != 8'd0);
    assign sat_ovf       = is_finite_pow && (biased_exp >= 17'sd255);
    assign sat_udf       = is_finite_pow && (biased_exp <= 17'sd0);

    always_comb begin
        pack_result_next = {res_sign, biased_exp[7:0], acc_mant_reg[FP32_FRAC_W-1:0]};
        if (cls_reg == CLS_NAN) begin
            pack_result_next = FP32_QNAN;
        end else if (n_reg == 8'd0) begin
            pack_result_next = FP32_ONE;
        end else if (cls_reg == CLS_ZERO) begin
            pack_result_next = {res_sign, 31'd0};
        end else if (cls_reg == CLS_INF) begin
            pack_result_next = {res_sign, FP32_INF[30:0]};
        end else if (sat_ovf) begin
            pack_result_next = {res_sign, FP32_INF[30:0]};
        end else if (sat_udf) begin
            pack_result_next = {res_sign, 31'd0};
        end
    end

    // ------------------------------------------------------------------
    // Control and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            bit_idx_reg   <= 3'd0;
            n_reg         <= 8'd0;
            sign_reg      <= 1'b0;
            cls_reg       <= CLS_ZERO;
            base_mant_reg <= '0;
            base_exp_reg  <= '0;
            acc_mant_reg  <= '0;
            acc_exp_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            result_reg    <= 32'd0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done_reg) begin
                        n_reg         <= N;
                        sign_reg      <= value[31];
                        cls_reg       <= fp32_classify(value);
                        base_mant_reg <= {1'b1, value[22:0]};
                        base_exp_reg  <= load_exp;
                        acc_mant_reg  <= {1'b1, 23'd0};
                        acc_exp_reg   <= '0;
                        bit_idx_reg   <= 3'd0;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (n_reg[bit_idx_reg]) begin
                        acc_mant_reg <= mul_p_mant;
                        acc_exp_reg  <= mul_p_exp;
                    end
                    state_reg <= ST_SQR;
                end
                ST_SQR: begin
                    // Squared even after the last bit so latency never varies.
                    base_mant_reg <= mul_p_mant;
                    base_exp_reg  <= mul_p_exp;
                    bit_idx_reg   <= bit_idx_reg + 3'd1;
                    state_reg     <= (bit_idx_reg == 3'd7) ? ST_PACK : ST_ACC;
                end
                default: begin   // ST_PACK
                    result_reg <= pack_result_next;
                    done_reg   <= 1'b1;
                    busy_reg   <= 1'b0;
                    state_reg  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef NTH_POWER_FLAGS_EN
    logic overflow_reg;
    logic underflow_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (state_reg == ST_PACK) begin
            overflow_reg  <= sat_ovf;
            underflow_reg <= sat_udf;
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`endif

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: doc/nth_power_fp.md
# nth_power_fp

Iterative IEEE-754 single-precision integer-power unit. Computes `value^N` for an 8-bit unsigned exponent `N` by square-and-multiply over a shared mantissa multiplier. It is the inverse companion of the CORDIC nth-root datapath, and its result feeds root/power round-trip checks and power-law stages in the same floating-point pipeline. It accepts a start/busy/done handshake and has fixed latency.

## Interface
- No parameters; all widths fixed (binary32, 8-bit N).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request. Sampled only when `busy`=0.
- `value` input 32: IEEE-754 single operand, `{S,E[7:0],F[22:0]}`.
- `N` input 8: unsigned exponent, 0..255.
- `busy` output 1: high from the cycle after acceptance until `done`.
- `done` output 1: one-cycle pulse when `result` is valid.
- `result` output 32: IEEE-754 single `value^N`. Holds until the next `done`.
- `overflow` output 1: only with `NTH_POWER_FLAGS_EN`. Valid with `done`.
- `underflow` output 1: only with `NTH_POWER_FLAGS_EN`. Valid with `done`.

## Operation
- **Reset:** `busy`=0, `done`=0, `result`=0x00000000, flags=0, FSM=IDLE.
- **FSM:** IDLE → (start) ACC → SQR → ACC … (8 ACC/SQR pairs, bit k=0..7 of N, LSB first) → PACK → IDLE.
- **Load (IDLE, start=1):**
  - Capture N and sign.
  - `base` = {mantissa 1.F (24b), unbiased exponent E−127 (16b signed)}.
  - `acc` = {1.0, 0}.
  - Classify the operand: zero/denormal (flushed to zero), inf, NaN, normal.
- **ACC, bit k:** if N[k]=1, `acc` ← `acc`×`base`; otherwise `acc` holds. Exactly one cycle either way.
- **SQR:** `base` ← `base`×`base`. Always executed, even after the last set bit (fixed latency).
- **Multiply:**
  - 24×24 → 48-bit product; exponents add.
  - If product[47]=1: keep [47:24], exponent +1. Otherwise keep [46:23].
  - Truncation; no rounding.
  - 16-bit signed exponent never wraps: |exp| ≤ 255·128.
- **PACK, result sign:** S & N[0].
- **PACK, result value, in priority order:**
  1. NaN in → 0x7FC00000.
  2. N=0 → 0x3F800000 (covers 0^0, inf^0).
  3. Zero/denormal in → signed zero.
  4. Inf in → signed inf.
  5. Biased exponent acc_exp+127 ≥ 255 → signed inf, overflow=1.
  6. acc_exp+127 ≤ 0 → signed zero, underflow=1 (no denormal output).
  7. Otherwise {sign, acc_exp+127, acc_mant[22:0]}.
- `start` while `busy`=1: ignored, no queueing.
- `start` in the same cycle as `done`: ignored. Accepted at earliest the cycle after.
- `value`/`N` may change after acceptance; captured copies are used.

## Timing
- Acceptance edge = cycle 0. `busy`=1 cycles 1..17 (16 ACC/SQR + PACK). `done`=1 and `result` updated in cycle 18; `busy`=0 in cycle 18.
- Latency is fixed at 18 cycles for all N and operand classes.
- Throughput: one operation per 19 cycles (restart on cycle 19).
- `rst_n` asserted mid-operation: immediate return to reset values. In-flight operation discarded, no `done`.
- All outputs registered.

## Configuration
- `NTH_POWER_FLAGS_EN` defined: `overflow`/`underflow` ports exist, registered, updated with `done`, cleared by reset.
- Not defined: ports and flag registers absent. Saturation behaviour is unchanged.

## Structure
- Shared package `fp32_pkg`:
  - Field widths, bias 127.
  - Constants `FP32_ONE`=0x3F800000, `FP32_QNAN`=0x7FC00000, `FP32_INF`=0x7F800000.
  - Operand-class enum {ZERO, NORM, INF, NAN}.
  - FSM state enum.
- One sub-module: `fp_mant_mul`. Combinational: 24b×24b mantissa plus 16b signed exponent in, normalized truncated mantissa/exponent out. Single instance, operand mux selected by FSM state.

## Test plan
- 2.0 (0x40000000), N=3 → `done` exactly 18 cycles after acceptance, `result`=0x41000000. 1.5 (0x3FC00000), N=2 → 0x40100000.
- −3.0 (0xC0400000), N=3 → 0xC1D80000. Same operand, N=2 → 0x41100000.
- Any value including 0x00000000, 0x7F800000; N=0 → 0x3F800000. NaN (0x7FC00001), N=5 → 0x7FC00000.
- 2.0, N=255 → 0x7F800000, overflow=1. 0.5 (0x3F000000), N=200 → 0x00000000, underflow=1. 2.0, N=127 → 0x7F000000, flags 0.
- Second `start` pulsed at cycles 5 and 18 → ignored, exactly one `done`. `start` at cycle 19 → accepted, new `done` at cycle 37.
- `rst_n` low at cycle 9 → `busy`/`done`/`result` return to 0 asynchronously, no `done` pulse. Next operation completes normally.
